long_division_arbiter: RTL and testbench
========================================

Name: long_division_arbiter

Overview:
- Shares one long-division AXI4-S engine between N_REQ_P requesters, e.g. several frequency-enable/clock-divider blocks that each need a divisor computed from a configured frequency.
- Arbitrates two-beat division requests (dividend, then divisor with tlast) round-robin and tags each request with the requester index on tid.
- Routes each quotient back to its requester by tid.
- Sits between the requesters' div_egr/div_ing ports and the divider's ing/egr ports.

Parameters:
- N_REQ_P, 4, number of requesters (2..16)
- AXI_DATA_WIDTH_P, 32, tdata width
- AXI_ID_WIDTH_P, 2, divider tid width; must be >= $clog2(N_REQ_P)
- TIMEOUT_CYCLES_P, 1024, response timeout; used only with the optional feature

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_tvalid  in  N_REQ_P  per-requester request valid
- req_tready  out  N_REQ_P  per-requester request ready
- req_tdata  in  N_REQ_P*AXI_DATA_WIDTH_P  flattened request data; requester k uses slice k
- req_tlast  in  N_REQ_P  marks the divisor beat
- rsp_tvalid  out  N_REQ_P  one-cycle response pulse to requester k
- rsp_tdata  out  AXI_DATA_WIDTH_P  quotient, broadcast to all requesters
- rsp_tuser  out  N_REQ_P  divider tuser (overflow/div-by-zero) for requester k
- div_egr_tvalid  out  1  request valid to divider
- div_egr_tready  in  1  request ready from divider
- div_egr_tdata  out  AXI_DATA_WIDTH_P  request data to divider
- div_egr_tlast  out  1  request tlast to divider
- div_egr_tid  out  AXI_ID_WIDTH_P  granted requester index
- div_ing_tvalid  in  1  divider result valid; no backpressure
- div_ing_tdata  in  AXI_DATA_WIDTH_P  quotient
- div_ing_tlast  in  1  ignored
- div_ing_tid  in  AXI_ID_WIDTH_P  index of the requester the result belongs to
- div_ing_tuser  in  1  divider flag
- cr_clear  in  1  clears the sticky status bits
- sr_unexpected_rsp  out  1  sticky: result arrived with bad or unowned tid
- sr_timeout  out  N_REQ_P  sticky per-requester timeout flags

Behaviour:
- Reset (rst_n low at clk edge): clears FSM to IDLE, grant pointer to N_REQ_P-1, all outstanding flags, all sticky bits.
  - All outputs 0 after reset.
  - An in-flight packet is abandoned; the divider is reset by the same rst_n.
- Eligibility: requester k is eligible when req_tvalid[k]=1 and outstanding[k]=0.
- FSM, two states: IDLE and GRANT.
- IDLE: if any requester is eligible, register grant = first eligible index after the last granted index (round-robin, wrapping), then go to GRANT. All req_tready and div_egr_tvalid are 0 in IDLE.
- GRANT: combinational pass-through for the granted index g:
  - div_egr_tvalid = req_tvalid[g]
  - req_tready[g] = div_egr_tready
  - div_egr_tdata = req_tdata slice g; div_egr_tlast = req_tlast[g]; div_egr_tid = g
  - All other req_tready = 0.
- End of GRANT: on the accepted beat with tlast=1, set outstanding[g]=1, update the pointer to g, return to IDLE. The grant is held across any number of beats until tlast is accepted.
- Latency: a request raised in cycle N while the arbiter is IDLE appears on div_egr_tvalid in cycle N+1. Back-to-back packets are separated by one IDLE cycle.
- Responses: when div_ing_tvalid=1 with tid=k, k<N_REQ_P and outstanding[k]=1:
  - rsp_tvalid[k]=1 and rsp_tuser[k]=div_ing_tuser, registered (one-cycle latency).
  - rsp_tdata is registered from div_ing_tdata.
  - outstanding[k] is cleared.
- Unexpected response: tid >= N_REQ_P or outstanding[k]=0 → response dropped, sr_unexpected_rsp set.
- Simultaneous events: a response clearing outstanding[k] in the same cycle requester k becomes eligible takes effect first. Requester k may be granted in the next IDLE evaluation.
- A requester dropping tvalid mid-packet is not an error; the grant is held.
- cr_clear: clears the sticky bits in the next cycle; a set event in the same cycle wins.
- Width rule: div_egr_tid = g zero-extended to AXI_ID_WIDTH_P.

Optional Feature:
- Macro: LONG_DIVISION_ARBITER_TIMEOUT_EN.
- Defined: each requester has a counter, reset on grant completion and counting while outstanding[k]=1.
  - When the counter reaches TIMEOUT_CYCLES_P: clear outstanding[k], set sr_timeout[k], emit no rsp.
  - A late response for k is then treated as unexpected.
- Not defined: no counters; sr_timeout is tied to 0 and outstanding[k] is cleared only by a response.

Test Plan:
- Single request: requester 1 sends 100000000 then 10000000 (tlast), divider returns 10 with tid=1 → div_egr_tid=1 on both beats, first beat one cycle after req_tvalid; rsp_tvalid[1] pulses once with rsp_tdata=10.
- Contention: all 4 requesters valid simultaneously after reset → grant order 0,1,2,3; each packet is intact; one IDLE cycle between packets.
- Fairness: requesters 0 and 2 continuously re-request after each response → grants alternate 0,2,0,2; no requester is granted twice while the other waits.
- Backpressure: div_egr_tready low for 5 cycles mid-packet → tdata and tlast held stable, grant unchanged; other requesters' tready stay 0.
- Bad response: div_ing_tvalid with tid=3 while nothing is outstanding → no rsp_tvalid, sr_unexpected_rsp=1; cr_clear pulse → returns to 0.
- Reset mid-packet: rst_n low for one edge after the dividend beat → div_egr_tvalid=0 and FSM in IDLE; with the macro defined and no response for requester 2, sr_timeout[2]=1 after TIMEOUT_CYCLES_P cycles.

Source files
------------

// File: rtl/long_division_arbiter.sv
// Round-robin arbiter sharing one AXI4-S long-division engine between N_REQ_P requesters.
// Optional per-requester response timeout: define LONG_DIVISION_ARBITER_TIMEOUT_EN.
module long_division_arbiter #(
    parameter int N_REQ_P          = 4,
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 2,
    parameter int TIMEOUT_CYCLES_P = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ_P-1:0]                    req_tvalid,
    output logic [N_REQ_P-1:0]                    req_tready,
    input  logic [N_REQ_P*AXI_DATA_WIDTH_P-1:0]   req_tdata,
    input  logic [N_REQ_P-1:0]                    req_tlast,
    output logic [N_REQ_P-1:0]                    rsp_tvalid,
    output logic [AXI_DATA_WIDTH_P-1:0]           rsp_tdata,
    output logic [N_REQ_P-1:0]                    rsp_tuser,
    output logic                                  div_egr_tvalid,
    input  logic                                  div_egr_tready,
    output logic [AXI_DATA_WIDTH_P-1:0]           div_egr_tdata,
    output logic                                  div_egr_tlast,
    output logic [AXI_ID_WIDTH_P-1:0]             div_egr_tid,
    input  logic                                  div_ing_tvalid,
    input  logic [AXI_DATA_WIDTH_P-1:0]           div_ing_tdata,
    input  logic                                  div_ing_tlast,
    input  logic [AXI_ID_WIDTH_P-1:0]             div_ing_tid,
    input  logic                                  div_ing_tuser,
    input  logic                                  cr_clear,
    output logic                                  sr_unexpected_rsp,
    output logic [N_REQ_P-1:0]                    sr_timeout
);

    localparam int GW = $clog2(N_REQ_P);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                      state_q, state_d;
    logic [GW-1:0]               grant_q, grant_d;
    logic [GW-1:0]               ptr_q, ptr_d;
    logic [N_REQ_P-1:0]          outstanding_q, outstanding_d;
    logic [N_REQ_P-1:0]          rsp_tvalid_q, rsp_tvalid_d;
    logic [N_REQ_P-1:0]          rsp_tuser_q, rsp_tuser_d;
    logic [AXI_DATA_WIDTH_P-1:0] rsp_tdata_q, rsp_tdata_d;
    logic                        sr_unexpected_q, sr_unexpected_d;
    logic [N_REQ_P-1:0]          sr_timeout_q, sr_timeout_d;

    logic [N_REQ_P-1:0]          eligible;
    logic                        any_eligible;
    logic [GW-1:0]               next_grant;
    logic                        in_grant;
    logic                        pkt_done;
    logic [N_REQ_P-1:0]          rsp_hit;
    logic                        rsp_unexpected;
    logic [N_REQ_P-1:0]          tmo_fire;
    logic                        unused_ing_tlast;

    assign unused_ing_tlast = div_ing_tlast;

    // Walk from the farthest candidate to the nearest so the last hit is the
    // first eligible index after the pointer.
    always_comb begin
        eligible     = req_tvalid & ~outstanding_q;
        any_eligible = 1'b0;
        next_grant   = ptr_q;
        for (int i = N_REQ_P; i >= 1; i--) begin
            if (eligible[(int'(ptr_q) + i) % N_REQ_P]) begin
                any_eligible = 1'b1;
                next_grant   = GW'((int'(ptr_q) + i) % N_REQ_P);
            end
        end
    end

    always_comb begin
        in_grant       = (state_q == GRANT);
        req_tready     = '0;
        div_egr_tvalid = 1'b0;
        div_egr_tdata  = '0;
        div_egr_tlast  = 1'b0;
        div_egr_tid    = '0;
        if (in_grant) begin
            req_tready[grant_q]      = div_egr_tready;
            div_egr_tvalid           = req_tvalid[grant_q];
            div_egr_tdata            = req_tdata[int'(grant_q)*AXI_DATA_WIDTH_P +: AXI_DATA_WIDTH_P];
            div_egr_tlast            = req_tlast[grant_q];
            div_egr_tid[GW-1:0]      = grant_q;
        end
        pkt_done = in_grant & req_tvalid[grant_q] & div_egr_tready & req_tlast[grant_q];
    end

    // A result is only routed when its tid names a requester still waiting on one.
    always_comb begin
        rsp_hit        = '0;
        rsp_unexpected = 1'b0;
        if (div_ing_tvalid) begin
            rsp_unexpected = 1'b1;
            for (int k = 0; k < N_REQ_P; k++) begin
                if (div_ing_tid == AXI_ID_WIDTH_P'(k) && outstanding_q[k]) begin
                    rsp_hit[k]     = 1'b1;
                    rsp_unexpected = 1'b0;
                end
            end
        end
    end

`ifdef LONG_DIVISION_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES_P + 1);

    logic [CW-1:0] tmo_cnt_q [N_REQ_P];
    logic [CW-1:0] tmo_cnt_d [N_REQ_P];

    always_comb begin
        tmo_fire = '0;
        for (int k = 0; k < N_REQ_P; k++) begin
            tmo_cnt_d[k] = '0;
            if (outstanding_q[k] && !rsp_hit[k]) begin
                if (tmo_cnt_q[k] == CW'(TIMEOUT_CYCLES_P - 1)) begin
                    tmo_fire[k] = 1'b1;
                end else begin
                    tmo_cnt_d[k] = tmo_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REQ_P; k++) begin
                tmo_cnt_q[k] <= '0;
            end
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_fire = '0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    grant_d = next_grant;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (pkt_done) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        outstanding_d = outstanding_q & ~rsp_hit & ~tmo_fire;
        if (pkt_done) begin
            outstanding_d[grant_q] = 1'b1;
        end

        rsp_tvalid_d = rsp_hit;
        rsp_tuser_d  = rsp_hit & {N_REQ_P{div_ing_tuser}};
        rsp_tdata_d  = (|rsp_hit) ? div_ing_tdata : rsp_tdata_q;

        // Sticky bits: a set event in the same cycle as cr_clear wins.
        sr_unexpected_d = (sr_unexpected_q & ~cr_clear) | rsp_unexpected;
        sr_timeout_d    = (sr_timeout_q & {N_REQ_P{~cr_clear}}) | tmo_fire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            ptr_q           <= GW'(N_REQ_P - 1);
            outstanding_q   <= '0;
            rsp_tvalid_q    <= '0;
            rsp_tuser_q     <= '0;
            rsp_tdata_q     <= '0;
            sr_unexpected_q <= 1'b0;
            sr_timeout_q    <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            ptr_q           <= ptr_d;
            outstanding_q   <= outstanding_d;
            rsp_tvalid_q    <= rsp_tvalid_d;
            rsp_tuser_q     <= rsp_tuser_d;
            rsp_tdata_q     <= rsp_tdata_d;
            sr_unexpected_q <= sr_unexpected_d;
            sr_timeout_q    <= sr_timeout_d;
        end
    end

    assign rsp_tvalid        = rsp_tvalid_q;
    assign rsp_tuser         = rsp_tuser_q;
    assign rsp_tdata         = rsp_tdata_q;
    assign sr_unexpected_rsp = sr_unexpected_q;
    assign sr_timeout        = sr_timeout_q;

endmodule

// File: tb/tb_long_division_arbiter.sv
// Scoreboard bench for long_division_arbiter; the bench also plays the divider engine.
module tb_long_division_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             tv [N];
    logic [W-1:0]     td [N];
    logic             tl [N];

    logic [N-1:0]     req_tvalid, req_tready, req_tlast;
    logic [N*W-1:0]   req_tdata;
    logic [N-1:0]     rsp_tvalid, rsp_tuser, sr_timeout;
    logic [W-1:0]     rsp_tdata;
    logic             div_egr_tvalid, div_egr_tready, div_egr_tlast;
    logic [W-1:0]     div_egr_tdata;
    logic [IDW-1:0]   div_egr_tid;
    logic             div_ing_tvalid, div_ing_tlast, div_ing_tuser;
    logic [W-1:0]     div_ing_tdata;
    logic [IDW-1:0]   div_ing_tid;
    logic             cr_clear, sr_unexpected_rsp;

    logic             egr_rdy;
    logic             mdl_v, mdl_u, man_v, man_u;
    logic [W-1:0]     mdl_q, man_d;
    logic [IDW-1:0]   mdl_tid, man_tid;
    logic             div_auto;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_tvalid[k]        = tv[k];
            req_tlast[k]         = tl[k];
            req_tdata[k*W +: W]  = td[k];
        end
    end

    assign div_egr_tready = egr_rdy;
    assign div_ing_tvalid = mdl_v | man_v;
    assign div_ing_tdata  = man_v ? man_d : mdl_q;
    assign div_ing_tid    = man_v ? man_tid : mdl_tid;
    assign div_ing_tuser  = man_v ? man_u : mdl_u;
    assign div_ing_tlast  = div_ing_tvalid;

    long_division_arbiter #(
        .N_REQ_P(N), .AXI_DATA_WIDTH_P(W), .AXI_ID_WIDTH_P(IDW), .TIMEOUT_CYCLES_P(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata), .req_tlast(req_tlast),
        .rsp_tvalid(rsp_tvalid), .rsp_tdata(rsp_tdata), .rsp_tuser(rsp_tuser),
        .div_egr_tvalid(div_egr_tvalid), .div_egr_tready(div_egr_tready), .div_egr_tdata(div_egr_tdata),
        .div_egr_tlast(div_egr_tlast), .div_egr_tid(div_egr_tid),
        .div_ing_tvalid(div_ing_tvalid), .div_ing_tdata(div_ing_tdata), .div_ing_tlast(div_ing_tlast),
        .div_ing_tid(div_ing_tid), .div_ing_tuser(div_ing_tuser),
        .cr_clear(cr_clear), .sr_unexpected_rsp(sr_unexpected_rsp), .sr_timeout(sr_timeout)
    );

    typedef struct packed { logic [W-1:0] data; logic last; logic [IDW-1:0] tid; } beat_t;
    typedef struct packed { logic [7:0] k; logic [W-1:0] data; logic user; } rsp_t;
    typedef struct packed { logic [IDW-1:0] tid; logic [W-1:0] q; logic user; logic [31:0] due; } pend_t;

    beat_t exp_egr [$];
    rsp_t  exp_rsp [$];
    pend_t pend [$];
    int    beat_cyc [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_pkt(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] q, input logic u);
        exp_egr.push_back('{data: a, last: 1'b0, tid: IDW'(k)});
        exp_egr.push_back('{data: b, last: 1'b1, tid: IDW'(k)});
        exp_rsp.push_back('{k: 8'(k), data: q, user: u});
    endtask

    // Egress monitor: checks every accepted beat and feeds the divider model.
    initial begin
        beat_t        e;
        pend_t        p;
        logic [W-1:0] dividend;
        dividend = '0;
        forever begin
            @(negedge clk);
            if (rst_n && div_egr_tvalid && div_egr_tready) begin
                beat_cyc.push_back(cyc);
                if (exp_egr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL egr_extra_beat actual tid=%0d data=%0h required=no beat", div_egr_tid, div_egr_tdata);
                end else begin
                    e = exp_egr.pop_front();
                    chk("egr_tdata", 64'(div_egr_tdata), 64'(e.data));
                    chk("egr_tlast", 64'(div_egr_tlast), 64'(e.last));
                    chk("egr_tid", 64'(div_egr_tid), 64'(e.tid));
                end
                if (!div_egr_tlast) begin
                    dividend = div_egr_tdata;
                end else begin
                    p.tid = div_egr_tid;
                    if (div_egr_tdata == '0) begin
                        p.q    = '1;
                        p.user = 1'b1;
                    end else begin
                        p.q    = dividend / div_egr_tdata;
                        p.user = 1'b0;
                    end
                    p.due = 32'(cyc + 2);
                    pend.push_back(p);
                end
            end
        end
    end

    // Divider model result driver.
    initial begin
        pend_t p;
        mdl_v = 1'b0; mdl_u = 1'b0; mdl_q = '0; mdl_tid = '0;
        forever begin
            @(posedge clk);
            #1;
            mdl_v = 1'b0;
            if (!rst_n) begin
                pend.delete();
            end else if (div_auto && pend.size() > 0 && cyc >= int'(pend[0].due)) begin
                p       = pend.pop_front();
                mdl_v   = 1'b1;
                mdl_tid = p.tid;
                mdl_q   = p.q;
                mdl_u   = p.user;
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t         r;
        logic [N-1:0] onehot;
        forever begin
            @(negedge clk);
            if (rsp_tvalid != '0) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_extra actual rsp_tvalid=%0h required=0", rsp_tvalid);
                end else begin
                    r = exp_rsp.pop_front();
                    onehot = '0;
                    onehot[r.k] = 1'b1;
                    chk("rsp_tvalid", 64'(rsp_tvalid), 64'(onehot));
                    chk("rsp_tdata", 64'(rsp_tdata), 64'(r.data));
                    chk("rsp_tuser", 64'(rsp_tuser), 64'(r.user ? onehot : '0));
                end
            end
        end
    end

    task automatic send_beat(input int k, input logic [W-1:0] d, input logic last);
        bit hs;
        int n;
        tv[k] = 1'b1; td[k] = d; tl[k] = last;
        hs = 1'b0; n = 0;
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = req_tready[k];
            @(posedge clk);
            n++;
        end
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL req%0d_handshake actual=no tready required=tready within 300 cycles", k);
        end
        #1;
        tv[k] = 1'b0; tl[k] = 1'b0;
    endtask

    task automatic send_pkt(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        send_beat(k, a, 1'b0);
        send_beat(k, b, 1'b1);
    endtask

    task automatic wait_rsp(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_tvalid[k] && n < 300);
        chk($sformatf("rsp%0d_arrived", k), 64'(rsp_tvalid[k]), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() > 0 || exp_egr.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        for (int k = 0; k < N; k++) begin
            tv[k] = 1'b0; td[k] = '0; tl[k] = 1'b0;
        end
        egr_rdy = 1'b1; cr_clear = 1'b0; div_auto = 1'b1;
        man_v = 1'b0; man_u = 1'b0; man_d = '0; man_tid = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl_outputs", 64'({req_tready, rsp_tvalid, rsp_tuser, sr_timeout, sr_unexpected_rsp,
                                      div_egr_tvalid, div_egr_tlast, div_egr_tid}), 64'(0));
        chk("reset_data_outputs", {rsp_tdata, div_egr_tdata}, 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request with first-beat latency.
        expect_pkt(1, 100000000, 10000000, 10, 1'b0);
        fork
            send_pkt(1, 100000000, 10000000);
            begin
                @(negedge clk);
                chk("t1_idle_cycle_valid", 64'(div_egr_tvalid), 64'(0));
                @(negedge clk);
                chk("t1_latency_valid", 64'(div_egr_tvalid), 64'(1));
                chk("t1_latency_tid", 64'(div_egr_tid), 64'(1));
            end
        join
        wait_rsp(1);
        @(negedge clk);
        chk("t1_rsp_single_pulse", 64'(rsp_tvalid), 64'(0));
        drain();

        // Contention after reset: order 0,1,2,3 with one idle cycle between packets.
        pulse_reset();
        base = beat_cyc.size();
        expect_pkt(0, 1000, 10, 100, 1'b0);
        expect_pkt(1, 77, 7, 11, 1'b0);
        expect_pkt(2, 5, 0, 32'hFFFF_FFFF, 1'b1);
        expect_pkt(3, 12345, 5, 2469, 1'b0);
        fork
            send_pkt(0, 1000, 10);
            send_pkt(1, 77, 7);
            send_pkt(2, 5, 0);
            send_pkt(3, 12345, 5);
        join
        drain();
        chk("t2_beat_count", 64'(beat_cyc.size() - base), 64'(8));
        if (beat_cyc.size() >= base + 8) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_beats_adjacent", 64'(beat_cyc[base+2*i+1] - beat_cyc[base+2*i]), 64'(1));
            end
            for (int i = 0; i < 3; i++) begin
                chk("t2_idle_gap", 64'(beat_cyc[base+2*i+2] - beat_cyc[base+2*i+1]), 64'(2));
            end
        end

        // Fairness: 0 and 2 re-request after each response.
        expect_pkt(0, 40, 8, 5, 1'b0);
        expect_pkt(2, 100, 4, 25, 1'b0);
        expect_pkt(0, 90, 9, 10, 1'b0);
        expect_pkt(2, 64, 16, 4, 1'b0);
        expect_pkt(0, 81, 3, 27, 1'b0);
        expect_pkt(2, 7, 2, 3, 1'b0);
        fork
            begin
                send_pkt(0, 40, 8);  wait_rsp(0);
                send_pkt(0, 90, 9);  wait_rsp(0);
                send_pkt(0, 81, 3);  wait_rsp(0);
            end
            begin
                send_pkt(2, 100, 4); wait_rsp(2);
                send_pkt(2, 64, 16); wait_rsp(2);
                send_pkt(2, 7, 2);   wait_rsp(2);
            end
        join
        drain();

        // Backpressure mid-packet while requester 1 waits.
        expect_pkt(3, 500, 20, 25, 1'b0);
        expect_pkt(1, 63, 9, 7, 1'b0);
        fork
            send_pkt(3, 500, 20);
            begin
                int n;
                n = 0;
                while (!(div_egr_tvalid && div_egr_tready && !div_egr_tlast) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("t4_first_beat_seen", 64'(n < 50), 64'(1));
                @(posedge clk);
                #1;
                egr_rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_hold_valid", 64'(div_egr_tvalid), 64'(1));
                    chk("t4_hold_tdata", 64'(div_egr_tdata), 64'(20));
                    chk("t4_hold_tlast", 64'(div_egr_tlast), 64'(1));
                    chk("t4_hold_tid", 64'(div_egr_tid), 64'(3));
                    chk("t4_all_tready_low", 64'(req_tready), 64'(0));
                end
                @(posedge clk);
                #1;
                egr_rdy = 1'b1;
            end
            begin
                wait (egr_rdy == 1'b0);
                send_pkt(1, 63, 9);
            end
        join
        drain();

        // Unexpected responses and sticky clear.
        man_v = 1'b1; man_tid = 2'd3; man_d = 32'd123; man_u = 1'b0;
        @(posedge clk); #1; man_v = 1'b0;
        @(negedge clk);
        chk("t5_no_rsp", 64'(rsp_tvalid), 64'(0));
        chk("t5_unexpected_set", 64'(sr_unexpected_rsp), 64'(1));
        @(posedge clk); #1; cr_clear = 1'b1;
        @(posedge clk); #1; cr_clear = 1'b0;
        @(negedge clk);
        chk("t5_cleared", 64'(sr_unexpected_rsp), 64'(0));
        man_v = 1'b1; man_tid = 2'd1; cr_clear = 1'b1;
        @(posedge clk); #1; man_v = 1'b0; cr_clear = 1'b0;
        @(negedge clk);
        chk("t5_set_beats_clear", 64'(sr_unexpected_rsp), 64'(1));
        chk("t5_unowned_no_rsp", 64'(rsp_tvalid), 64'(0));
        @(posedge clk); #1; cr_clear = 1'b1;
        @(posedge clk); #1; cr_clear = 1'b0;

        // Reset mid-packet.
        exp_egr.push_back('{data: 32'd1000, last: 1'b0, tid: 2'd2});
        send_beat(2, 1000, 1'b0);
        pulse_reset();
        @(negedge clk);
        chk("t6_egr_valid_after_reset", 64'(div_egr_tvalid), 64'(0));
        chk("t6_outputs_after_reset", 64'({req_tready, rsp_tvalid, sr_timeout, sr_unexpected_rsp, div_egr_tid}), 64'(0));
        @(negedge clk);
        chk("t6_idle_stays", 64'(div_egr_tvalid), 64'(0));

        // Requester 2 left waiting with no divider response.
        div_auto = 1'b0;
        exp_egr.push_back('{data: 32'd300, last: 1'b0, tid: 2'd2});
        exp_egr.push_back('{data: 32'd3, last: 1'b1, tid: 2'd2});
        send_pkt(2, 300, 3);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("t6_no_early_timeout", 64'(sr_timeout), 64'(0));
        repeat (40) @(posedge clk);
        @(negedge clk);
`ifdef LONG_DIVISION_ARBITER_TIMEOUT_EN
        chk("t6_timeout_set", 64'(sr_timeout), 64'(4'b0100));
        @(posedge clk); #1;
        man_v = 1'b1; man_tid = 2'd2; man_d = 32'd100; man_u = 1'b0;
        @(posedge clk); #1; man_v = 1'b0;
        @(negedge clk);
        chk("t6_late_rsp_dropped", 64'(rsp_tvalid), 64'(0));
        chk("t6_late_rsp_unexpected", 64'(sr_unexpected_rsp), 64'(1));
`else
        chk("t6_no_timeout_flag", 64'(sr_timeout), 64'(0));
        @(posedge clk); #1;
        exp_rsp.push_back('{k: 8'd2, data: 32'd100, user: 1'b0});
        man_v = 1'b1; man_tid = 2'd2; man_d = 32'd100; man_u = 1'b0;
        @(posedge clk); #1; man_v = 1'b0;
        @(negedge clk);
        chk("t6_late_rsp_accepted", 64'(sr_unexpected_rsp), 64'(0));
`endif
        drain();
        chk("sb_egr_drained", 64'(exp_egr.size()), 64'(0));
        chk("sb_rsp_drained", 64'(exp_rsp.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
